// File: rtl/sar_pkg.sv
// ============================================================================
// Module   : sar_pkg
// Brief    : Shared types and helpers for the SAR ADC sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sar_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } sar_state_t;

  localparam logic SAR_SINGLE = 1'b0;
  localparam logic SAR_CONT   = 1'b1;

  function automatic logic [31:0] sar_midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sar_ch_rr.sv
// ============================================================================
// Module   : sar_ch_rr
// Brief    : Combinational round-robin channel picker (first set mask bit
//            strictly after last_i, wrapping).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_ch_rr #(
  parameter int NCH  = 2,
  parameter int CH_W = 1
) (
  input  logic [NCH-1:0]  mask_i,
  input  logic [CH_W-1:0] last_i,
  output logic [CH_W-1:0] next_o,
  output logic            none_o
);

  int              w_sum;
  logic [CH_W-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    next_o = '0;
    none_o = 1'b1;
    w_sum  = 0;
    w_cand = '0;
    for (int i = NCH; i >= 1; i--) begin
      w_sum = int'(last_i) + i;
      if (w_sum >= NCH) w_sum = w_sum - NCH;
      w_cand = CH_W'(w_sum);
      if (mask_i[w_cand]) begin
        next_o = w_cand;
        none_o = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sar_seq_ctrl.sv
// ============================================================================
// Module   : sar_seq_ctrl
// Brief    : SAR ADC sequencer: sample, bit-serial conversion, round-robin
//            channel scan and single-entry result buffer with overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sar_seq_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NCH      = 2,
  parameter int SMPL_CYC = 2,
  parameter int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             cmp_i,
  output logic             sample_o,
  output logic [CH_W-1:0]  ch_sel_o,
  output logic [WIDTH-1:0] dac_o,
  output logic             busy_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic [CH_W-1:0]  res_ch_o,
  output logic             ovf_o
);

  localparam int               CNT_W    = (SMPL_CYC > 1) ? $clog2(SMPL_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SMPL_CYC - 1);
  localparam logic [WIDTH-1:0] MID      = WIDTH'(sar_midscale(WIDTH));
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NCH - 1);

  sar_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] sar_q, sar_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]  rch_q, rch_d;
  logic             ovf_q, ovf_d;

  logic             w_none;
  logic             w_active;
  logic             w_load;
  logic [CH_W-1:0]  w_next;
  logic [CH_W-1:0]  w_last;

  // In DONE the channel just converted is the round-robin reference.
  assign w_last   = (state_q == DONE) ? ch_q : last_q;
  assign w_active = en & ~w_none;
  assign w_load   = (state_q == DONE) & en;

  sar_ch_rr #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_rr (
    .mask_i (ch_mask),
    .last_i (w_last),
    .next_o (w_next),
    .none_o (w_none)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    sar_d   = sar_q;
    ch_d    = ch_q;
    last_d  = last_q;
    vld_d   = vld_q & ~res_ready_i;
    data_d  = data_q;
    rch_d   = rch_q;
    ovf_d   = 1'b0;

    case (state_q)
      IDLE: if (w_active && (mode == SAR_CONT || start)) state_d = SAMPLE;
      SAMPLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = CONVERT;
          cnt_d   = '0;
        end
      end
      CONVERT: begin
        // Resolve the current trial bit, then raise the next lower one.
        if (!cmp_i) sar_d = sar_q & ~bit_q;
        sar_d = sar_d | (bit_q >> 1);
        bit_d = bit_q >> 1;
        if (bit_q[0]) state_d = DONE;
      end
      DONE:    state_d = (mode == SAR_CONT && w_active) ? SAMPLE : IDLE;
      default: state_d = IDLE;
    endcase

    if (!en) state_d = IDLE;

    if (state_d == SAMPLE && state_q != SAMPLE) ch_d = w_next;
    if (state_d == IDLE || state_d == SAMPLE) begin
      sar_d = MID;
      bit_d = MID;
    end

    if (w_load) begin
      vld_d  = 1'b1;
      data_d = sar_q;
      rch_d  = ch_q;
      last_d = ch_q;
      ovf_d  = vld_q & ~res_ready_i;
    end

    sample_d = (state_d == SAMPLE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= MID;
      sar_q    <= MID;
      ch_q     <= '0;
      last_q   <= CH_LAST;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      rch_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sar_q    <= sar_d;
      ch_q     <= ch_d;
      last_q   <= last_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      rch_q    <= rch_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sample_o    = sample_q;
  assign ch_sel_o    = ch_q;
  assign dac_o       = sar_q;
  assign busy_o      = busy_q;
  assign res_valid_o = vld_q;
  assign res_data_o  = data_q;
  assign res_ch_o    = rch_q;
  assign ovf_o       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sar_seq_ctrl.sv
// ============================================================================
// Module   : tb_sar_seq_ctrl
// Brief    : Self-checking bench for sar_seq_ctrl with an ideal comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sar_seq_ctrl;

  localparam int WIDTH    = 8;
  localparam int NCH      = 2;
  localparam int SMPL_CYC = 2;
  localparam int CH_W     = 1;

  logic             clk = 1'b0;
  logic             rst, en, mode, start, cmp_i, res_ready_i;
  logic [NCH-1:0]   ch_mask;
  logic             sample_o, busy_o, res_valid_o, ovf_o;
  logic [CH_W-1:0]  ch_sel_o, res_ch_o;
  logic [WIDTH-1:0] dac_o, res_data_o;

  logic [7:0] vin0, vin1;
  int         n_chk  = 0;
  int         n_fail = 0;
  int         last_ch;

  always #5 clk = ~clk;

  // Ideal comparator on the currently selected analog input.
  assign cmp_i = ((ch_sel_o != 1'b0) ? vin1 : vin0) >= dac_o;

  sar_seq_ctrl #(
    .WIDTH(WIDTH), .NCH(NCH), .SMPL_CYC(SMPL_CYC), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
    .ch_mask(ch_mask), .cmp_i(cmp_i), .sample_o(sample_o), .ch_sel_o(ch_sel_o),
    .dac_o(dac_o), .busy_o(busy_o), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_ch_o(res_ch_o),
    .ovf_o(ovf_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NCH-1:0] m, input int last);
    for (int o = 1; o <= NCH; o++) begin
      int c;
      c = (last + o) % NCH;
      if (((m >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] vin_of(input int c);
    return (c == 0) ? vin0 : vin1;
  endfunction

  // DAC code while deciding bit k: input's bits above k, bit k set, rest clear.
  function automatic logic [7:0] trial(input logic [7:0] v, input int k);
    logic [7:0] hi;
    hi = (v >> (k + 1)) << (k + 1);
    return hi | (8'd1 << k);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_sample"}, sample_o, 0);
    check({tag, "_chsel"}, ch_sel_o, 0);
    check({tag, "_dac"}, dac_o, 8'h80);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_valid"}, res_valid_o, 0);
    check({tag, "_data"}, res_data_o, 0);
    check({tag, "_rch"}, res_ch_o, 0);
    check({tag, "_ovf"}, ovf_o, 0);
  endtask

  task automatic single(input logic [7:0] v0, input logic [7:0] v1, input logic [1:0] m);
    int         ec;
    logic [7:0] ev;
    vin0 = v0; vin1 = v1; ch_mask = m; mode = 1'b0; res_ready_i = 1'b0;
    ec = pick(m, last_ch);
    ev = vin_of(ec);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ss_busy", busy_o, 1);
    check("ss_chsel", ch_sel_o, ec);
    for (int c = 1; c <= 11; c++) begin
      if (c <= SMPL_CYC) begin
        check("ss_sample_hi", sample_o, 1);
        check("ss_dac_mid", dac_o, 8'h80);
      end else if (c <= SMPL_CYC + WIDTH) begin
        check("ss_sample_lo", sample_o, 0);
        check("ss_dac_trial", dac_o, trial(ev, WIDTH - 1 - (c - SMPL_CYC - 1)));
      end
      check("ss_valid_early", res_valid_o, 0);
      tick();
    end
    check("ss_valid", res_valid_o, 1);
    check("ss_data", res_data_o, ev);
    check("ss_rch", res_ch_o, ec);
    check("ss_idle", busy_o, 0);
    check("ss_ovf", ovf_o, 0);
    last_ch = ec;
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    check("ss_consumed", res_valid_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         prev_t, n_ev, ec, t;
    logic [7:0] ev;

    rst = 1'b1; en = 1'b1; mode = 1'b0; start = 1'b0; ch_mask = '0;
    res_ready_i = 1'b0; vin0 = 8'h00; vin1 = 8'h00;
    last_ch = NCH - 1;
    #1;
    check_reset_vals("rst");
    tick(); tick();
    rst = 1'b0;
    tick();
    check_reset_vals("post_rst");

    // Directed conversions: reference code and both extremes.
    single(8'hA5, 8'h3C, 2'b01);
    single(8'h00, 8'h11, 2'b01);
    single(8'h22, 8'hFF, 2'b10);
    single(8'hFF, 8'h00, 2'b01);

    // Randomised single-shot conversions with random masks.
    for (int i = 0; i < 6; i++)
      single(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             2'($urandom_range(1, 3)));

    // Continuous scan of both channels, consumer always ready.
    vin0 = 8'($urandom_range(0, 255)); vin1 = 8'($urandom_range(0, 255));
    ch_mask = 2'b11; res_ready_i = 1'b1; mode = 1'b1;
    prev_t = -1; n_ev = 0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      if (cyc == 56) mode = 1'b0;
      tick();
      check("cont_ovf", ovf_o, 0);
      if (res_valid_o) begin
        ec = pick(ch_mask, last_ch);
        check("cont_ch", res_ch_o, ec);
        check("cont_data", res_data_o, vin_of(ec));
        if (prev_t >= 0) check("cont_period", cyc - prev_t, SMPL_CYC + WIDTH + 1);
        prev_t = cyc; last_ch = ec; n_ev++;
      end
      if (cyc > 56 && !busy_o && !res_valid_o) break;
    end
    check("cont_drained", busy_o, 0);
    check("cont_events", (n_ev >= 4) ? 1 : 0, 1);

    // Continuous with a stalled consumer: overwrite and same-cycle handshake.
    res_ready_i = 1'b0; mode = 1'b1;
    vin0 = 8'($urandom_range(0, 255)); vin1 = 8'($urandom_range(0, 255));
    t = 0;
    while (!res_valid_o && t < 40) begin tick(); t++; end
    check("stall_first_valid", res_valid_o, 1);
    ec = pick(ch_mask, last_ch); last_ch = ec;
    check("stall_ch1", res_ch_o, ec);
    check("stall_data1", res_data_o, vin_of(ec));
    check("stall_ovf1", ovf_o, 0);
    for (int i = 0; i < 10; i++) tick();
    check("stall_hold", res_valid_o, 1);
    tick();
    ec = pick(ch_mask, last_ch); last_ch = ec;
    check("stall_ovf_pulse", ovf_o, 1);
    check("stall_ch2", res_ch_o, ec);
    check("stall_data2", res_data_o, vin_of(ec));
    tick();
    check("stall_ovf_one_cycle", ovf_o, 0);
    for (int i = 0; i < 9; i++) tick();
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0; mode = 1'b0;
    ec = pick(ch_mask, last_ch); last_ch = ec;
    check("hs_load_ovf", ovf_o, 0);
    check("hs_load_valid", res_valid_o, 1);
    check("hs_load_ch", res_ch_o, ec);
    check("hs_load_data", res_data_o, vin_of(ec));
    t = 0;
    while (busy_o && t < 30) begin tick(); t++; end
    check("stall_drain", busy_o, 0);
    ec = pick(ch_mask, last_ch); last_ch = ec;
    check("stall_final_ch", res_ch_o, ec);
    check("stall_final_data", res_data_o, vin_of(ec));
    res_ready_i = 1'b1; tick(); res_ready_i = 1'b0;
    check("stall_cleared", res_valid_o, 0);

    // Enable dropped in the middle of a conversion.
    ch_mask = 2'b01; vin0 = 8'h6B;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    en = 1'b0;
    tick();
    check("en_busy", busy_o, 0);
    check("en_sample", sample_o, 0);
    check("en_dac", dac_o, 8'h80);
    check("en_valid", res_valid_o, 0);
    for (int i = 0; i < 12; i++) tick();
    check("en_no_result", res_valid_o, 0);
    en = 1'b1;

    // Asynchronous reset in the middle of a conversion with a result pending.
    ch_mask = 2'b10; vin1 = 8'h5A;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    check("arst_pre_valid", res_valid_o, 1);
    check("arst_pre_data", res_data_o, 8'h5A);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1;
    check_reset_vals("arst");
    tick();
    rst = 1'b0;
    last_ch = NCH - 1;

    // Empty mask: start must be ignored.
    ch_mask = 2'b00;
    start = 1'b1; tick(); start = 1'b0;
    check("mask0_busy", busy_o, 0);
    check("mask0_sample", sample_o, 0);
    for (int i = 0; i < 3; i++) tick();
    check("mask0_still_idle", busy_o, 0);

    // After reset the scan restarts at channel 0.
    single(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
